// File: rtl/mux_nch_pkg.sv
// Shared constants and types for the N-channel registered multiplexer.
// Optional round-robin arbitration is enabled with MUX_NCH_REG_RR_EN.
package mux_nch_pkg;

    // Default data width per channel and default channel count
    localparam int W_DEF = 4;
    localparam int N_DEF = 8;

    // Supported channel count range
    localparam int N_MIN = 2;
    localparam int N_MAX = 64;

    // Channel selection policy
    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage

// File: rtl/mux_nch_rr_arb.sv
// Round-robin arbiter: picks the first requesting channel at or above ptr,
// wrapping modulo N. Only instantiated when MUX_NCH_REG_RR_EN is defined.
module mux_nch_rr_arb
    import mux_nch_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int SW = (N > 2) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    int idx;

    // Scan from ptr upward, keeping the first requester encountered
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_nch_reg.sv
// N-channel multiplexer with a one-entry registered output stage,
// per-channel valid/ready handshake and an output transfer counter.
// Defining MUX_NCH_REG_RR_EN adds the rr_mode port and round-robin selection.
module mux_nch_reg
    import mux_nch_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF,
    localparam int SW = (N > 2) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
`ifdef MUX_NCH_REG_RR_EN
    input  logic           rr_mode,
`endif
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           err_sel,
    output logic [15:0]    xfer_cnt
);

    mode_e         mode;
    logic [SW-1:0] chosen;
    logic          chosenOk;
    logic          loadOk;
    logic          xferIn;
    logic          xferOut;
    logic [W-1:0]  selData;

    logic [W-1:0]  outData_q,  outData_d;
    logic [SW-1:0] outCh_q,    outCh_d;
    logic          outValid_q, outValid_d;
    logic          errSel_q,   errSel_d;
    logic [15:0]   xferCnt_q,  xferCnt_d;

    assign loadOk  = !outValid_q || out_ready;
    assign xferOut = outValid_q && out_ready;
    assign xferIn  = |(in_valid & in_ready);

`ifdef MUX_NCH_REG_RR_EN
    logic [SW-1:0] gntIdx;
    logic          gntAny;
    logic [SW-1:0] ptr_q, ptr_d;

    assign mode = rr_mode ? MODE_RR : MODE_FIXED;

    mux_nch_rr_arb #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_idx (gntIdx),
        .gnt_any (gntAny)
    );

    // Advance the pointer past the granted channel on each round-robin load
    always_comb begin
        ptr_d = ptr_q;
        if (mode == MODE_RR && xferIn) begin
            ptr_d = (gntIdx == SW'(N - 1)) ? '0 : gntIdx + SW'(1);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    assign mode = MODE_FIXED;
`endif

    // Pick the channel being offered a slot and whether that choice is usable
    always_comb begin
        chosen   = sel;
        chosenOk = int'(sel) < N;
`ifdef MUX_NCH_REG_RR_EN
        if (mode == MODE_RR) begin
            chosen   = gntIdx;
            chosenOk = gntAny;
        end
`endif
    end

    // One-hot ready toward the chosen channel plus its data word
    always_comb begin
        in_ready = '0;
        selData  = '0;
        for (int c = 0; c < N; c++) begin
            in_ready[c] = rst_n && loadOk && chosenOk && (SW'(c) == chosen);
            if (SW'(c) == chosen) selData = in_data[c*W +: W];
        end
    end

    // Output stage next state: reload on input transfer, drain on output transfer
    always_comb begin
        outData_d  = outData_q;
        outCh_d    = outCh_q;
        outValid_d = outValid_q;
        xferCnt_d  = xferCnt_q + (xferOut ? 16'd1 : 16'd0);
        errSel_d   = (mode == MODE_FIXED) && loadOk && !chosenOk;
        if (xferIn) begin
            outData_d  = selData;
            outCh_d    = chosen;
            outValid_d = 1'b1;
        end else if (xferOut) begin
            outValid_d = 1'b0;
        end
    end

    // Output stage, error pulse and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outData_q  <= '0;
            outCh_q    <= '0;
            outValid_q <= 1'b0;
            errSel_q   <= 1'b0;
            xferCnt_q  <= '0;
        end else begin
            outData_q  <= outData_d;
            outCh_q    <= outCh_d;
            outValid_q <= outValid_d;
            errSel_q   <= errSel_d;
            xferCnt_q  <= xferCnt_d;
        end
    end

    assign out_data  = outData_q;
    assign out_ch    = outCh_q;
    assign out_valid = outValid_q;
    assign err_sel   = errSel_q;
    assign xfer_cnt  = xferCnt_q;

endmodule

// File: tb/tb_mux_nch_reg.sv
// Directed self-checking bench for mux_nch_reg (N=8 main instance, N=6 for
// out-of-range select). Round-robin scenario runs when MUX_NCH_REG_RR_EN is defined.
module tb_mux_nch_reg;

    logic        clk;
    logic        rst_n;
    logic [31:0] inData;
    logic [7:0]  inValid;
    logic [7:0]  inReady;
    logic [2:0]  sel;
    logic [3:0]  outData;
    logic [2:0]  outCh;
    logic        outValid;
    logic        outReady;
    logic        errSel;
    logic [15:0] xferCnt;

    logic [23:0] inData6;
    logic [5:0]  inValid6;
    logic [5:0]  inReady6;
    logic [2:0]  sel6;
    logic [3:0]  outData6;
    logic [2:0]  outCh6;
    logic        outValid6;
    logic        outReady6;
    logic        errSel6;
    logic [15:0] xferCnt6;

`ifdef MUX_NCH_REG_RR_EN
    logic        rrMode;
`endif

    int testsRun;
    int testsFailed;

    mux_nch_reg #(.W(4), .N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (inData),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .sel       (sel),
`ifdef MUX_NCH_REG_RR_EN
        .rr_mode   (rrMode),
`endif
        .out_data  (outData),
        .out_ch    (outCh),
        .out_valid (outValid),
        .out_ready (outReady),
        .err_sel   (errSel),
        .xfer_cnt  (xferCnt)
    );

    mux_nch_reg #(.W(4), .N(6)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (inData6),
        .in_valid  (inValid6),
        .in_ready  (inReady6),
        .sel       (sel6),
`ifdef MUX_NCH_REG_RR_EN
        .rr_mode   (1'b0),
`endif
        .out_data  (outData6),
        .out_ch    (outCh6),
        .out_valid (outValid6),
        .out_ready (outReady6),
        .err_sel   (errSel6),
        .xfer_cnt  (xferCnt6)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        inValid = 8'hFF;
        sel     = 3'd3;
        rst_n   = 1'b0;
        #1;
        testsRun++;
        if (inReady !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_in_ready: got %h expected 00", inReady);
        end
        testsRun++;
        if (outValid !== 1'b0 || outData !== 4'h0 || outCh !== 3'd0 || errSel !== 1'b0 || xferCnt !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h ch=%0d err=%b cnt=%0d expected all 0",
                     outValid, outData, outCh, errSel, xferCnt);
        end
        inValid = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fixed_routing();
        @(negedge clk);
        for (int c = 0; c < 8; c++) inData[c*4 +: 4] = 4'(c);
        inData[12 +: 4] = 4'hA;
        sel      = 3'd3;
        outReady = 1'b0;
        inValid  = 8'h08;
        #1;
        testsRun++;
        if (inReady !== 8'h08) begin
            testsFailed++;
            $display("[TB] FAIL route_in_ready: got %h expected 08", inReady);
        end
        @(negedge clk);
        testsRun++;
        if (outValid !== 1'b1 || outData !== 4'hA || outCh !== 3'd3) begin
            testsFailed++;
            $display("[TB] FAIL route_output: got valid=%b data=%h ch=%0d expected 1 A 3",
                     outValid, outData, outCh);
        end
    endtask

    task automatic test_backpressure();
        inData[12 +: 4] = 4'h5;
        for (int i = 0; i < 4; i++) begin
            #1;
            testsRun++;
            if (outData !== 4'hA || inReady !== 8'h00 || outValid !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL backpressure_hold[%0d]: got data=%h ready=%h valid=%b expected A 00 1",
                         i, outData, inReady, outValid);
            end
            @(negedge clk);
        end
        outReady = 1'b1;
        #1;
        testsRun++;
        if (inReady !== 8'h08) begin
            testsFailed++;
            $display("[TB] FAIL backpressure_release_ready: got %h expected 08", inReady);
        end
        @(negedge clk);
        testsRun++;
        if (outValid !== 1'b1 || outData !== 4'h5 || xferCnt !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL backpressure_reload: got valid=%b data=%h cnt=%0d expected 1 5 1",
                     outValid, outData, xferCnt);
        end
        inValid = 8'h00;
        @(negedge clk);
        testsRun++;
        if (outValid !== 1'b0 || xferCnt !== 16'd2) begin
            testsFailed++;
            $display("[TB] FAIL backpressure_drain: got valid=%b cnt=%0d expected 0 2", outValid, xferCnt);
        end
    endtask

    task automatic test_streaming();
        applyReset();
        sel      = 3'd3;
        outReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inData[12 +: 4] = 4'(i);
            inValid = 8'h08;
            @(negedge clk);
            testsRun++;
            if (outValid !== 1'b1 || outData !== 4'(i)) begin
                testsFailed++;
                $display("[TB] FAIL stream_beat[%0d]: got valid=%b data=%h expected 1 %h",
                         i, outValid, outData, 4'(i));
            end
        end
        inValid = 8'h00;
        @(negedge clk);
        testsRun++;
        if (xferCnt !== 16'd10 || outValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stream_count: got cnt=%0d valid=%b expected 10 0", xferCnt, outValid);
        end
    endtask

    task automatic test_invalid_sel();
        @(negedge clk);
        for (int c = 0; c < 6; c++) inData6[c*4 +: 4] = 4'(c + 8);
        outReady6 = 1'b1;
        sel6      = 3'd7;
        inValid6  = 6'h3F;
        #1;
        testsRun++;
        if (inReady6 !== 6'h00) begin
            testsFailed++;
            $display("[TB] FAIL badsel_in_ready: got %h expected 00", inReady6);
        end
        @(negedge clk);
        testsRun++;
        if (errSel6 !== 1'b1 || outValid6 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL badsel_err_pulse: got err=%b valid=%b expected 1 0", errSel6, outValid6);
        end
        sel6 = 3'd2;
        @(negedge clk);
        testsRun++;
        if (errSel6 !== 1'b0 || outValid6 !== 1'b1 || outCh6 !== 3'd2 || outData6 !== 4'hA) begin
            testsFailed++;
            $display("[TB] FAIL badsel_recover: got err=%b valid=%b ch=%0d data=%h expected 0 1 2 A",
                     errSel6, outValid6, outCh6, outData6);
        end
        inValid6 = 6'h00;
    endtask

    task automatic test_reset_mid();
        applyReset();
        sel      = 3'd3;
        outReady = 1'b1;
        inValid  = 8'h08;
        repeat (38) @(negedge clk);
        testsRun++;
        if (xferCnt !== 16'd37 || outValid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midreset_setup: got cnt=%0d valid=%b expected 37 1", xferCnt, outValid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (outValid !== 1'b0 || xferCnt !== 16'd0 || inReady !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL midreset_async: got valid=%b cnt=%0d ready=%h expected 0 0 00",
                     outValid, xferCnt, inReady);
        end
        inValid = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        testsRun++;
        if (outValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_no_replay: got valid=%b expected 0", outValid);
        end
    endtask

`ifdef MUX_NCH_REG_RR_EN
    task automatic test_round_robin();
        logic [2:0] expCh [5];
        expCh[0] = 3'd0; expCh[1] = 3'd2; expCh[2] = 3'd5; expCh[3] = 3'd7; expCh[4] = 3'd0;
        rrMode = 1'b1;
        applyReset();
        sel      = 3'd3;
        outReady = 1'b1;
        inValid  = 8'b1010_0101;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            testsRun++;
            if (outValid !== 1'b1 || outCh !== expCh[i] || errSel !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL rr_order[%0d]: got valid=%b ch=%0d err=%b expected 1 %0d 0",
                         i, outValid, outCh, errSel, expCh[i]);
            end
        end
        inValid = 8'h00;
        rrMode  = 1'b0;
        @(negedge clk);
    endtask
`endif

    // Run every scenario in order, then report
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n     = 1'b0;
        inData    = '0;
        inValid   = '0;
        sel       = '0;
        outReady  = 1'b0;
        inData6   = '0;
        inValid6  = '0;
        sel6      = '0;
        outReady6 = 1'b1;
`ifdef MUX_NCH_REG_RR_EN
        rrMode    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_fixed_routing();
        test_backpressure();
        test_streaming();
        test_invalid_sel();
        test_reset_mid();
`ifdef MUX_NCH_REG_RR_EN
        test_round_robin();
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
